pocket_video_sched: RTL

Frame-synchronous scheduler between the core video output and the Pocket display pipeline. It owns the scaler slot and the video source, which are switched by a valid/ready request. Every change takes effect only at a frame boundary. The block emits the scaler slot command word during the vsync pulse, then forces black for a programmable number of frames so the display never shows a torn or mis-scaled frame. Its output feeds the APF video pins directly, with single-cycle HS/VS pulses and RGB zero whenever DE is low, except in the slot word cycle.

---
 rtl/pocket_video_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pocket_video_sched.sv
// rtl/pocket_video_sched.sv - frame-synchronous scaler slot / video source scheduler for the APF video pins
// Define POCKET_VIDEO_TESTPAT_EN to build the colour-bar test pattern source.
module pocket_video_sched #(
  parameter int SLOT_W       = 3,
  parameter int BLANK_FRAMES = 2
) (
  input  logic              iPCLK,
  input  logic              iRSTn,
  input  logic [23:0]       iRGB,
  input  logic              iVS,
  input  logic              iHS,
  input  logic              iDE,
  input  logic              iREQ_VALID,
  input  logic [SLOT_W-1:0] iREQ_SLOT,
  input  logic              iREQ_SRC,
  output logic              oREQ_READY,
  output logic [23:0]       oRGB,
  output logic              oVS,
  output logic              oHS,
  output logic              oDE,
  output logic [SLOT_W-1:0] oSLOT_ACTIVE,
  output logic              oSRC_ACTIVE,
  output logic              oBUSY
);

  typedef enum logic [1:0] {
    sIdle,
    sPending,
    sBlank
  } stateT;

  localparam logic [3:0] blankLoad = 4'(BLANK_FRAMES);

  logic [23:0]       s1Rgb;
  logic              s1Vs;
  logic              s1Hs;
  logic              s1De;
  logic              s2Vs;
  logic              s2Hs;
  logic              vsRise;
  logic              hsRise;
  logic              applyNow;
  stateT             state;
  logic [SLOT_W-1:0] pendSlot;
  logic              pendSrc;
  logic [3:0]        blankCnt;
  logic [23:0]       slotWord;
  logic [23:0]       pixel;

  // Syncs reset high so a level held across reset release is never seen as an edge.
  always_ff @(posedge iPCLK) begin
    if (!iRSTn) begin
      s1Rgb <= 24'd0;
      s1Vs  <= 1'b1;
      s1Hs  <= 1'b1;
      s1De  <= 1'b0;
      s2Vs  <= 1'b1;
      s2Hs  <= 1'b1;
    end else begin
      s1Rgb <= iRGB;
      s1Vs  <= iVS;
      s1Hs  <= iHS;
      s1De  <= iDE;
      s2Vs  <= s1Vs;
      s2Hs  <= s1Hs;
    end
  end

  assign vsRise   = s1Vs & ~s2Vs;
  assign hsRise   = s1Hs & ~s2Hs;
  assign applyNow = (state == sPending) && vsRise;
  assign slotWord = {11'd0, 10'(pendSlot), 3'd0};

`ifdef POCKET_VIDEO_TESTPAT_EN
  logic [10:0] xCnt;
  logic [23:0] barRgb;

  // Saturates instead of wrapping so over-long lines stay on the last bar.
  always_ff @(posedge iPCLK) begin
    if (!iRSTn) begin
      xCnt <= 11'd0;
    end else if (hsRise) begin
      xCnt <= 11'd0;
    end else if (s1De && (xCnt != 11'h7FF)) begin
      xCnt <= xCnt + 11'd1;
    end
  end

  always_comb begin
    barRgb = 24'h000000;
    case (xCnt[8:6])
      3'd0:    barRgb = 24'hFFFFFF;
      3'd1:    barRgb = 24'hFFFF00;
      3'd2:    barRgb = 24'h00FFFF;
      3'd3:    barRgb = 24'h00FF00;
      3'd4:    barRgb = 24'hFF00FF;
      3'd5:    barRgb = 24'hFF0000;
      3'd6:    barRgb = 24'h0000FF;
      default: barRgb = 24'h000000;
    endcase
  end

  assign pixel = oSRC_ACTIVE ? barRgb : s1Rgb;
`else
  assign pixel = oSRC_ACTIVE ? 24'd0 : s1Rgb;
`endif

  always_ff @(posedge iPCLK) begin
    if (!iRSTn) begin
      state        <= sIdle;
      pendSlot     <= '0;
      pendSrc      <= 1'b0;
      oSLOT_ACTIVE <= '0;
      oSRC_ACTIVE  <= 1'b0;
      blankCnt     <= 4'd0;
      oREQ_READY   <= 1'b1;
      oBUSY        <= 1'b0;
    end else begin
      case (state)
        sIdle: begin
          // A vsRise in the accepting cycle is deliberately not used for the apply.
          if (iREQ_VALID) begin
            pendSlot   <= iREQ_SLOT;
            pendSrc    <= iREQ_SRC;
            state      <= sPending;
            oREQ_READY <= 1'b0;
            oBUSY      <= 1'b1;
          end
        end
        sPending: begin
          if (vsRise) begin
            oSLOT_ACTIVE <= pendSlot;
            oSRC_ACTIVE  <= pendSrc;
            blankCnt     <= blankLoad;
            if (blankLoad != 4'd0) begin
              state <= sBlank;
            end else begin
              state      <= sIdle;
              oREQ_READY <= 1'b1;
              oBUSY      <= 1'b0;
            end
          end
        end
        sBlank: begin
          if (vsRise) begin
            if (blankCnt <= 4'd1) begin
              blankCnt   <= 4'd0;
              state      <= sIdle;
              oREQ_READY <= 1'b1;
              oBUSY      <= 1'b0;
            end else begin
              blankCnt <= blankCnt - 4'd1;
            end
          end
        end
        default: begin
          state      <= sIdle;
          oREQ_READY <= 1'b1;
          oBUSY      <= 1'b0;
        end
      endcase
    end
  end

  // The slot word owns the oVS cycle of an apply; every other oVS cycle is black.
  always_ff @(posedge iPCLK) begin
    if (!iRSTn) begin
      oRGB <= 24'd0;
      oVS  <= 1'b0;
      oHS  <= 1'b0;
      oDE  <= 1'b0;
    end else begin
      oVS <= vsRise;
      oHS <= hsRise;
      oDE <= s1De;
      if (applyNow) begin
        oRGB <= slotWord;
      end else if (vsRise || !s1De || (state == sBlank)) begin
        oRGB <= 24'd0;
      end else begin
        oRGB <= pixel;
      end
    end
  end

endmodule
